// File: rtl/fnd_pkg.sv
// Shared constants for the FND (7-segment) display blocks.
// Segment patterns are active-low {g,f,e,d,c,b,a}; the dp bit is added by the user.
package fnd_pkg;

    localparam int IDX_W = 3;
    localparam logic [IDX_W-1:0] IDX_LAST = 3'd7;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [7:0] SEL_OFF = 8'hFF;

    // Blink burst phase: PH_ON lets the scan drive the selects, PH_OFF holds them all inactive.
    typedef enum logic {
        PH_OFF = 1'b0,
        PH_ON  = 1'b1
    } blink_ph_e;

endpackage

// File: rtl/fnd_scan_drv_bcd_to_7seg.sv
// Combinational BCD digit to active-low 7-segment pattern; 10-15 show a dash.
module bcd_to_7seg
    import fnd_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Pure lookup; the default covers the non-BCD codes.
    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/fnd_scan_drv.sv
// Eight-digit common-anode FND scan driver: frame-buffered BCD display with
// leading-zero blanking, ghost-suppression dead time and a finite blink burst.
//
// blink phase | meaning
// ------------+---------------------------------------------------------
// PH_ON       | selects follow the scan (idle, or "on" half of a burst)
// PH_OFF      | all selects inactive; scan and frame latch keep running
module fnd_scan_drv
    import fnd_pkg::*;
#(
    parameter int DEAD_CLKS     = 100,
    parameter int BLINK_HALF_MS = 250,
    parameter int BLINK_TOGGLES = 6
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_pls_1k,
    input  logic [31:0] i_bcd8d,
    input  logic [7:0]  i_dp,
    input  logic        i_lz_blank,
    input  logic        i_blink_trig,
    output logic [7:0]  o_fnd_sel,
    output logic [7:0]  o_fnd_seg,
    output logic        o_frame
);

    localparam int DEAD_W = $clog2(DEAD_CLKS + 1);
    localparam int MS_W   = $clog2(BLINK_HALF_MS + 1);
    localparam int CNT_W  = $clog2(BLINK_TOGGLES + 1);

    localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CLKS);
    localparam logic [MS_W-1:0]   MS_LAST   = MS_W'(BLINK_HALF_MS - 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(BLINK_TOGGLES);

    logic [IDX_W-1:0]  idx;
    logic [31:0]       frame_bcd;
    logic [7:0]        frame_dp;
    logic [DEAD_W-1:0] dead_cnt;

    logic [CNT_W-1:0]  blink_cnt, blink_cnt_nxt;
    logic [MS_W-1:0]   ms_cnt, ms_cnt_nxt;
    blink_ph_e         phase, phase_nxt;

    logic              wrap;
    logic [3:0]        cur_digit;
    logic [6:0]        cur_seg7;
    logic [7:0]        lead_zero;
    logic              zero_run;
    logic [7:0]        sel_nxt;
    logic [7:0]        seg_nxt;

    assign wrap = i_pls_1k && (idx == IDX_LAST);

    // Digit index, frame buffer and dead-time counter; a tick always reloads the dead time.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            idx       <= '0;
            frame_bcd <= '0;
            frame_dp  <= '0;
            dead_cnt  <= '0;
            o_frame   <= 1'b0;
        end else begin
            o_frame <= wrap;
            if (wrap) begin
                frame_bcd <= i_bcd8d;
                frame_dp  <= i_dp;
            end
            if (i_pls_1k) begin
                idx      <= idx + 1'b1;
                dead_cnt <= DEAD_LOAD;
            end else if (dead_cnt != '0) begin
                dead_cnt <= dead_cnt - 1'b1;
            end
        end
    end

    // Blink next-state: a trigger restarts the burst; the last toggle forces the phase on.
    always_comb begin
        blink_cnt_nxt = blink_cnt;
        ms_cnt_nxt    = ms_cnt;
        phase_nxt     = phase;
        if (i_blink_trig) begin
            blink_cnt_nxt = CNT_LOAD;
            ms_cnt_nxt    = '0;
            phase_nxt     = PH_OFF;
        end else if (blink_cnt == '0) begin
            phase_nxt = PH_ON;
        end else if (i_pls_1k) begin
            if (ms_cnt == MS_LAST) begin
                ms_cnt_nxt    = '0;
                blink_cnt_nxt = blink_cnt - 1'b1;
                if (blink_cnt == CNT_W'(1))
                    phase_nxt = PH_ON;
                else
                    phase_nxt = (phase == PH_ON) ? PH_OFF : PH_ON;
            end else begin
                ms_cnt_nxt = ms_cnt + 1'b1;
            end
        end
    end

    // Blink state register.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            blink_cnt <= '0;
            ms_cnt    <= '0;
            phase     <= PH_ON;
        end else begin
            blink_cnt <= blink_cnt_nxt;
            ms_cnt    <= ms_cnt_nxt;
            phase     <= phase_nxt;
        end
    end

    // Leading-zero mask over the buffered frame; digit 0 is never blanked.
    always_comb begin
        lead_zero = 8'h00;
        zero_run  = i_lz_blank;
        for (int k = 7; k >= 1; k--) begin
            zero_run     = zero_run && (frame_bcd[4*k +: 4] == 4'h0);
            lead_zero[k] = zero_run;
        end
    end

    assign cur_digit = frame_bcd[{idx, 2'b00} +: 4];

    bcd_to_7seg u_dec (
        .bcd (cur_digit),
        .seg (cur_seg7)
    );

    // Next select/segment drive; selects stay off through dead time and blink-off.
    always_comb begin
        sel_nxt = ~(8'h01 << idx);
        if ((dead_cnt != '0) || (phase == PH_OFF))
            sel_nxt = SEL_OFF;
        seg_nxt = {~frame_dp[idx], lead_zero[idx] ? SEG_BLANK : cur_seg7};
    end

    // Registered pad drive.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            o_fnd_sel <= SEL_OFF;
            o_fnd_seg <= SEG_OFF;
        end else begin
            o_fnd_sel <= sel_nxt;
            o_fnd_seg <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_fnd_scan_drv.sv
// Directed bench for fnd_scan_drv with short dead time and blink timing.
module tb_fnd_scan_drv;

    logic        i_clk;
    logic        i_rstn;
    logic        i_pls_1k;
    logic [31:0] i_bcd8d;
    logic [7:0]  i_dp;
    logic        i_lz_blank;
    logic        i_blink_trig;
    logic [7:0]  o_fnd_sel;
    logic [7:0]  o_fnd_seg;
    logic        o_frame;

    int n_vec = 0;
    int n_err = 0;
    int idx_m = 0;

    fnd_scan_drv #(
        .DEAD_CLKS     (4),
        .BLINK_HALF_MS (2),
        .BLINK_TOGGLES (4)
    ) dut (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .i_pls_1k     (i_pls_1k),
        .i_bcd8d      (i_bcd8d),
        .i_dp         (i_dp),
        .i_lz_blank   (i_lz_blank),
        .i_blink_trig (i_blink_trig),
        .o_fnd_sel    (o_fnd_sel),
        .o_fnd_seg    (o_fnd_seg),
        .o_frame      (o_frame)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic pulse();
        i_pls_1k = 1'b1;
        step();
        i_pls_1k = 1'b0;
        idx_m = (idx_m + 1) % 8;
    endtask

    function automatic logic [7:0] sel_of(input int k);
        logic [7:0] one;
        one = 8'h01;
        return ~(one << k);
    endfunction

    // One scan tick: frame pulse, four dead clocks, then the new digit.
    task automatic tick_chk(input string tag, input logic [7:0] exp_seg);
        bit wrap;
        wrap = (idx_m == 7);
        pulse();
        chk({tag, "_frame"}, o_frame, wrap);
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 0) chk({tag, "_frame_end"}, o_frame, 1'b0);
            chk({tag, "_dead"}, o_fnd_sel, 8'hFF);
        end
        step();
        chk({tag, "_sel"}, o_fnd_sel, sel_of(idx_m));
        chk({tag, "_seg"}, o_fnd_seg, exp_seg);
    endtask

    task automatic tick_nochk();
        pulse();
        repeat (5) step();
    endtask

    task automatic tick_blk(input string tag, input bit on);
        pulse();
        repeat (5) step();
        chk(tag, o_fnd_sel, on ? sel_of(idx_m) : 8'hFF);
    endtask

    task automatic blink_trig();
        i_blink_trig = 1'b1;
        step();
        i_blink_trig = 1'b0;
    endtask

    initial begin
        i_rstn       = 1'b0;
        i_pls_1k     = 1'b0;
        i_bcd8d      = 32'h0;
        i_dp         = 8'h0;
        i_lz_blank   = 1'b0;
        i_blink_trig = 1'b0;
        step();
        step();
        chk("rst_sel", o_fnd_sel, 8'hFF);
        chk("rst_seg", o_fnd_seg, 8'hFF);
        chk("rst_frame", o_frame, 1'b0);
        i_rstn = 1'b1;
        step();
        chk("idle_sel", o_fnd_sel, 8'hFE);
        chk("idle_seg", o_fnd_seg, 8'hC0);

        // Scan and latch: empty frame first, then 00012345.
        i_bcd8d = 32'h00012345;
        for (int k = 1; k < 8; k++) tick_chk("pre", 8'hC0);
        tick_chk("scan_d0", 8'h92);
        tick_chk("scan_d1", 8'h99);
        tick_chk("scan_d2", 8'hB0);
        tick_chk("scan_d3", 8'hA4);

        // Tearing: change mid-frame, old digits 4..7 persist.
        i_bcd8d = 32'h99999999;
        tick_chk("tear_d4", 8'hF9);
        tick_chk("tear_d5", 8'hC0);
        tick_chk("tear_d6", 8'hC0);
        tick_chk("tear_d7", 8'hC0);
        tick_chk("tear_new_d0", 8'h90);
        tick_chk("tear_new_d1", 8'h90);

        // Leading-zero blanking with a dp on digit 2.
        i_bcd8d    = 32'h00000305;
        i_dp       = 8'h04;
        i_lz_blank = 1'b1;
        for (int k = 2; k < 8; k++) tick_chk("lz_old", 8'h90);
        tick_chk("lz_d0", 8'h92);
        tick_chk("lz_d1", 8'hC0);
        tick_chk("lz_d2", 8'h30);
        i_bcd8d = 32'h0;
        i_dp    = 8'h00;
        for (int k = 3; k < 8; k++) tick_chk("lz_blank", 8'hFF);
        tick_chk("lz0_d0", 8'hC0);
        for (int k = 1; k < 8; k++) tick_chk("lz0_hi", 8'hFF);

        // Invalid BCD shows a dash.
        i_bcd8d    = 32'h00000A00;
        i_lz_blank = 1'b0;
        tick_chk("inv_d0", 8'hC0);
        tick_chk("inv_d1", 8'hC0);
        tick_chk("inv_d2", 8'hBF);

        // Reset mid-scan at index 5.
        tick_nochk();
        tick_nochk();
        tick_nochk();
        i_rstn = 1'b0;
        step();
        chk("mrst_sel", o_fnd_sel, 8'hFF);
        chk("mrst_seg", o_fnd_seg, 8'hFF);
        chk("mrst_frame", o_frame, 1'b0);
        i_rstn = 1'b1;
        idx_m  = 0;
        step();
        chk("mrst_idle_sel", o_fnd_sel, 8'hFE);
        tick_chk("mrst_d1", 8'hC0);

        // Blink burst, then restart during the second off period.
        blink_trig();
        tick_blk("blk_p1", 1'b0);
        tick_blk("blk_p2", 1'b1);
        tick_blk("blk_p3", 1'b1);
        tick_blk("blk_p4", 1'b0);
        tick_blk("blk_p5", 1'b0);
        blink_trig();
        tick_blk("rblk_p1", 1'b0);
        tick_blk("rblk_p2", 1'b1);
        tick_blk("rblk_p3", 1'b1);
        tick_blk("rblk_p4", 1'b0);
        tick_blk("rblk_p5", 1'b0);
        tick_blk("rblk_p6", 1'b1);
        tick_blk("rblk_p7", 1'b1);
        tick_blk("rblk_p8", 1'b1);
        tick_blk("rblk_p9", 1'b1);
        tick_blk("rblk_p10", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fnd_scan_drv.md
Name: fnd_scan_drv

Overview:
- Consumer end of the 8-digit packed-BCD display bus produced by the timer's display calculator.
- Time-multiplexes eight common-anode 7-segment digits (FND) from a 32-bit BCD word, one digit per 1 kHz tick.
- Adds frame-buffered latching, leading-zero blanking, inter-digit ghost blanking, and a finite blink burst triggered by the timer's finish pulse.

Parameters:
- DEAD_CLKS, 100, clocks after each digit switch during which all selects are inactive (ghost suppression).
- BLINK_HALF_MS, 250, number of 1 kHz ticks per blink half-period.
- BLINK_TOGGLES, 6, half-periods per blink burst (6 = 3 off/on cycles).

Ports:
- i_clk  in  1  system clock
- i_rstn  in  1  reset, synchronous, active-low
- i_pls_1k  in  1  one-clock strobe at 1 kHz; scan and blink timebase
- i_bcd8d  in  32  packed BCD, digit k = bits [4k+3:4k], k=0 is least significant
- i_dp  in  8  decimal-point enable per digit, bit k = digit k
- i_lz_blank  in  1  1 = blank leading zeros
- i_blink_trig  in  1  one-clock pulse; starts/restarts blink burst
- o_fnd_sel  out  8  digit select, active-low, bit k = digit k
- o_fnd_seg  out  8  {dp,g,f,e,d,c,b,a}, active-low
- o_frame  out  1  one-clock pulse when a new frame is latched

Behaviour:
- Reset (i_clk edge with i_rstn=0): digit index 0, frame buffer 0, dp buffer 0, dead counter 0, blink count 0, blink phase on; o_fnd_sel=8'hFF, o_fnd_seg=8'hFF, o_frame=0. Reset mid-scan or mid-blink takes effect on that edge; no partial state retained.
- Scan: on a cycle with i_pls_1k=1, the index advances 0->1->...->7->0 (wrap). Index changes at the next edge.
- Frame latch: on the same edge where the index wraps 7->0, i_bcd8d and i_dp are captured into the frame buffer and o_frame pulses for one cycle. Input changes mid-frame are not displayed until the next frame, so there is no tearing.
- Dead time: on the edge the index advances, the dead counter is loaded with DEAD_CLKS. While it is nonzero, o_fnd_sel=8'hFF and the counter decrements each clock. The new digit drives on the first cycle after it reaches 0.
- Drive, registered with 1-cycle output latency from the combinational decode: o_fnd_sel has only bit[index] low; o_fnd_seg is the decode of buffered digit[index].
- Decode: 0-9 map to the standard active-low patterns, e.g. 0=8'hC0, 1=8'hF9, 8=8'h80. Values 10-15 display dash (g only, 8'hBF). Bit 7 (dp) is driven low iff buffered dp[index]=1.
- Leading-zero blanking, when i_lz_blank=1 and evaluated on the frame buffer: digits 7 downward that are 0, up to the first nonzero digit, emit seg=8'hFF but keep dp. Digit 0 is never blanked. A value of 15 counts as nonzero.
- Blink: i_blink_trig loads blink count=BLINK_TOGGLES, clears the ms counter and sets phase=off. This is true even mid-burst (restart).
  - While count>0, each i_pls_1k increments the ms counter.
  - At BLINK_HALF_MS-1 the ms counter clears, phase toggles and count decrements.
  - When count reaches 0, phase is forced on.
  - Phase off forces o_fnd_sel=8'hFF. Scanning and frame latching continue underneath.
- Simultaneous i_blink_trig and i_pls_1k: the trigger wins for blink state, and the scan still advances.
- Simultaneous frame wrap and dead-time load: both occur on the same edge.

Decomposition:
- Shared package (fnd_pkg): 7-segment pattern constants SEG_0..SEG_9, SEG_DASH, SEG_OFF, SEL_OFF, plus the digit index width.
- One natural sub-module: bcd_to_7seg, a combinational 4-bit to 7-bit active-low decoder, reusable by other display blocks.

Test Plan:
- Reset mid-scan: assert i_rstn=0 for 1 clock at index 5 -> next cycle sel=FF, seg=FF, o_frame=0; first i_pls_1k after release selects digit 1.
- Scan and latch: i_bcd8d=32'h00012345, i_lz_blank=0, DEAD_CLKS=4 -> o_frame pulses once per 8 ticks; digits 0..7 show 5,4,3,2,1,0,0,0 (5=8'h92); sel=FF for exactly 4 clocks after each tick.
- Tearing: change i_bcd8d to 32'h99999999 at index 3 -> digits 4..7 in the current frame still show the old values; new values appear only after the next o_frame.
- LZ blanking: i_bcd8d=32'h00000305, i_dp=8'h04, i_lz_blank=1 -> digits 7..3 seg=FF, digit 2 seg=8'h30 (3 with dp), digit 1 shows 0 (C0), digit 0 shows 5; all-zero word -> only digit 0 shows C0.
- Invalid BCD: digit 2 = 4'hA -> seg=8'hBF.
- Blink: BLINK_HALF_MS=2, BLINK_TOGGLES=4, pulse i_blink_trig -> sel=FF for 2 ticks, active 2, off 2, active thereafter; re-trigger during the second off period restarts the full 4-toggle burst.
